vl_strip_ctrl: RTL and testbench

//   Sequential strip-mining controller for vsetvl-class instructions. Accepts one config
//   {SEW, LMUL, AVL} per valid/ready handshake and computes VLMAX. Emits the sequence of
//   per-chunk vl values, with element base offsets, that covers AVL.

---
 rtl/vl_strip_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vl_strip_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vl_strip_ctrl.sv
// Strip-mining controller: takes one {SEW, LMUL, AVL} config, computes VLMAX and
// issues the per-chunk vl/base sequence covering AVL. Optional macro: VL_SPLIT_EN (balanced tail).
module vl_strip_ctrl #(
   parameter int VLEN  = 64,
   parameter int ELEN  = 64,
   parameter int AVL_W = 16,
   localparam int VL_W = $clog2(VLEN) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [2:0]       cfg_sew,
   input  logic [2:0]       cfg_lmul,
   input  logic [AVL_W-1:0] cfg_avl,
   input  logic             cfg_avl_max,
   input  logic             abort,
   output logic             chunk_valid,
   input  logic             chunk_ready,
   output logic [VL_W-1:0]  chunk_vl,
   output logic [AVL_W-1:0] chunk_base,
   output logic             chunk_last,
   output logic [VL_W-1:0]  vlmax,
   output logic             vill,
   output logic             cfg_err,
   output logic             busy
);

   // Both handshakes: a transfer happens on a rising edge where valid and ready are both high.
   typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

   state_t           state_q, state_n;
   logic [2:0]       sew_q, sew_n, lmul_q, lmul_n;
   logic [AVL_W-1:0] avl_q, avl_n, rem_q, rem_n, base_q, base_n, rem_t;
   logic             avl_max_q, avl_max_n;
   logic [VL_W-1:0]  vl_q, vl_n, vlmax_q, vlmax_n;
   logic             last_q, last_n, vill_q, vill_n, cfg_err_q, cfg_err_n;
   logic [VL_W:0]    ch;

   logic [31:0]      raw_vlmax;
   logic             calc_vill;
   logic [VL_W-1:0]  calc_vlmax;

   // Returns {last, vl} for a chunk starting with r elements remaining.
   function automatic logic [VL_W:0] chunk_of(input logic [AVL_W-1:0] r, input logic [VL_W-1:0] vm);
      logic [AVL_W:0] r_w, vm_w;
      r_w  = {1'b0, r};
      vm_w = '0;
      vm_w[VL_W-1:0] = vm;
      if (r_w <= vm_w) chunk_of = {1'b1, r[VL_W-1:0]};
`ifdef VL_SPLIT_EN
      else if (r_w < (vm_w << 1)) chunk_of = {1'b0, VL_W'((r_w + 1'b1) >> 1)};
`endif
      else chunk_of = {1'b0, vm};
   endfunction

   always_comb begin
      raw_vlmax = 32'(VLEN) >> ({1'b0, sew_q} + 4'd3);
      if (lmul_q[2]) raw_vlmax = raw_vlmax >> (4'd8 - {1'b0, lmul_q});
      else           raw_vlmax = raw_vlmax << lmul_q[1:0];
      calc_vill  = sew_q[2] || (lmul_q == 3'b100) ||
                   ((32'd8 << sew_q) > 32'(ELEN)) || (raw_vlmax == 32'd0);
      calc_vlmax = calc_vill ? '0 : raw_vlmax[VL_W-1:0];
   end

   always_comb begin
      state_n   = state_q;
      sew_n     = sew_q;
      lmul_n    = lmul_q;
      avl_n     = avl_q;
      avl_max_n = avl_max_q;
      rem_n     = rem_q;
      base_n    = base_q;
      vl_n      = vl_q;
      last_n    = last_q;
      vlmax_n   = vlmax_q;
      vill_n    = vill_q;
      cfg_err_n = 1'b0;
      rem_t     = '0;
      ch        = '0;
      // abort discards any same-cycle chunk handshake by leaving the datapath untouched
      if (abort && state_q != IDLE) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cfg_valid) begin
               sew_n     = cfg_sew;
               lmul_n    = cfg_lmul;
               avl_n     = cfg_avl;
               avl_max_n = cfg_avl_max;
               state_n   = CALC;
            end
            CALC: begin
               vlmax_n = calc_vlmax;
               vill_n  = calc_vill;
               if (calc_vill) begin
                  cfg_err_n = 1'b1;
                  state_n   = IDLE;
               end else begin
                  rem_t   = avl_max_q ? AVL_W'(calc_vlmax) : avl_q;
                  ch      = chunk_of(rem_t, calc_vlmax);
                  rem_n   = rem_t;
                  base_n  = '0;
                  vl_n    = ch[VL_W-1:0];
                  last_n  = ch[VL_W];
                  state_n = ISSUE;
               end
            end
            ISSUE: if (chunk_ready) begin
               rem_t  = rem_q - AVL_W'(vl_q);
               ch     = chunk_of(rem_t, vlmax_q);
               rem_n  = rem_t;
               base_n = base_q + AVL_W'(vl_q);
               vl_n   = ch[VL_W-1:0];
               last_n = ch[VL_W];
               if (last_q) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sew_q     <= '0;
         lmul_q    <= '0;
         avl_q     <= '0;
         avl_max_q <= 1'b0;
         rem_q     <= '0;
         base_q    <= '0;
         vl_q      <= '0;
         last_q    <= 1'b0;
         vlmax_q   <= '0;
         vill_q    <= 1'b1;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         sew_q     <= sew_n;
         lmul_q    <= lmul_n;
         avl_q     <= avl_n;
         avl_max_q <= avl_max_n;
         rem_q     <= rem_n;
         base_q    <= base_n;
         vl_q      <= vl_n;
         last_q    <= last_n;
         vlmax_q   <= vlmax_n;
         vill_q    <= vill_n;
         cfg_err_q <= cfg_err_n;
      end
   end

   assign cfg_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign chunk_valid = (state_q == ISSUE);
   assign chunk_vl    = vl_q;
   assign chunk_base  = base_q;
   assign chunk_last  = last_q;
   assign vlmax       = vlmax_q;
   assign vill        = vill_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vl_strip_ctrl.sv
// Self-checking bench for vl_strip_ctrl: directed scenarios plus randomized configs
// checked against an arithmetic VLMAX / chunk-list model.
module tb_vl_strip_ctrl;
   localparam int VLEN  = 64;
   localparam int ELEN  = 64;
   localparam int AVL_W = 16;
   localparam int VL_W  = $clog2(VLEN) + 1;
   localparam int W     = VL_W + AVL_W + 1;

   logic             clk, rst;
   logic             cfg_valid, cfg_ready, cfg_avl_max, abort;
   logic [2:0]       cfg_sew, cfg_lmul;
   logic [AVL_W-1:0] cfg_avl;
   logic             chunk_valid, chunk_ready, chunk_last;
   logic [VL_W-1:0]  chunk_vl, vlmax;
   logic [AVL_W-1:0] chunk_base;
   logic             vill, cfg_err, busy;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   vl_strip_ctrl #(.VLEN(VLEN), .ELEN(ELEN), .AVL_W(AVL_W)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul), .cfg_avl(cfg_avl), .cfg_avl_max(cfg_avl_max),
      .abort(abort), .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
      .chunk_vl(chunk_vl), .chunk_base(chunk_base), .chunk_last(chunk_last),
      .vlmax(vlmax), .vill(vill), .cfg_err(cfg_err), .busy(busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference model: VLMAX = VLEN * LMUL / SEW, floored
   function automatic int ref_vlmax(input int sew, input int lmul, output bit ill);
      int sew_bits, num, den, v;
      sew_bits = 8 << sew;
      num = (lmul < 4) ? (1 << lmul) : 1;
      den = (lmul < 4) ? 1 : (1 << (8 - lmul));
      v   = (VLEN * num) / (sew_bits * den);
      ill = (sew > 3) || (lmul == 4) || (sew_bits > ELEN) || (v == 0);
      return ill ? 0 : v;
   endfunction

   task automatic build_exp(input int vmax, input int avl);
      int rem, base, vl;
      logic [W-1:0] e;
      rem = avl;
      base = 0;
      exp_q.delete();
      do begin
         vl = (rem < vmax) ? rem : vmax;
`ifdef VL_SPLIT_EN
         if (rem > vmax && rem < 2 * vmax) vl = (rem + 1) / 2;
`endif
         rem = rem - vl;
         e = {VL_W'(vl), AVL_W'(base), (rem == 0)};
         exp_q.push_back(e);
         base = base + vl;
      end while (rem > 0);
   endtask

   // drivers
   task automatic send_cfg(input int sew, input int lmul, input int avl, input bit amax);
      int n;
      n = 0;
      while (!cfg_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cfg_ready_before_send", cfg_ready, 1);
      cfg_valid   = 1'b1;
      cfg_sew     = 3'(sew);
      cfg_lmul    = 3'(lmul);
      cfg_avl     = AVL_W'(avl);
      cfg_avl_max = amax;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("calc_busy", busy, 1);
      check("calc_no_chunk", chunk_valid, 0);
      @(negedge clk);
   endtask

   // mode 0: always ready, 1: toggle ready 1/0, 2: random ready
   task automatic run_cfg(input int sew, input int lmul, input int avl, input bit amax, input int mode);
      int vmax, cyc, budget;
      bit ill, done, held, r;
      logic [W-1:0] e;
      logic [VL_W-1:0] h_vl;
      logic [AVL_W-1:0] h_base;
      logic h_last;
      vmax = ref_vlmax(sew, lmul, ill);
      send_cfg(sew, lmul, avl, amax);
      check("vlmax", vlmax, vmax);
      check("vill", vill, ill);
      if (ill) begin
         check("cfg_err_pulse", cfg_err, 1);
         check("ill_no_chunk", chunk_valid, 0);
         check("ill_idle", busy, 0);
         @(negedge clk);
         check("cfg_err_clear", cfg_err, 0);
         check("ill_still_no_chunk", chunk_valid, 0);
      end else begin
         check("cfg_err_quiet", cfg_err, 0);
         build_exp(vmax, amax ? vmax : avl);
         budget = 8 * exp_q.size() + 50;
         cyc = 0; done = 0; held = 0;
         h_vl = '0; h_base = '0; h_last = 1'b0;
         while (!done && cyc < budget) begin
            case (mode)
               0: r = 1'b1;
               1: r = (cyc % 2 == 0);
               default: r = ($urandom_range(0, 3) != 0);
            endcase
            chunk_ready = r;
            if (held) begin
               check("stall_vl", chunk_vl, h_vl);
               check("stall_base", chunk_base, h_base);
               check("stall_last", chunk_last, h_last);
            end
            check("chunk_valid", chunk_valid, 1);
            if (chunk_valid && chunk_ready) begin
               held = 0;
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("chunk_vl", chunk_vl, e[W-1:AVL_W+1]);
                  check("chunk_base", chunk_base, e[AVL_W:1]);
                  check("chunk_last", chunk_last, e[0]);
               end
               if (chunk_last || exp_q.size() == 0) done = 1;
            end else if (chunk_valid) begin
               held = 1;
               h_vl = chunk_vl; h_base = chunk_base; h_last = chunk_last;
            end
            @(negedge clk);
            cyc++;
         end
         chunk_ready = 1'b0;
         check("chunks_done", done, 1);
         check("chunks_left", exp_q.size(), 0);
         check("busy_after_last", busy, 0);
         check("valid_after_last", chunk_valid, 0);
      end
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_sew = '0; cfg_lmul = '0; cfg_avl = '0;
      cfg_avl_max = 1'b0; abort = 1'b0; chunk_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_chunk_valid", chunk_valid, 0);
      check("rst_chunk_vl", chunk_vl, 0);
      check("rst_chunk_base", chunk_base, 0);
      check("rst_chunk_last", chunk_last, 0);
      check("rst_vlmax", vlmax, 0);
      check("rst_vill", vill, 1);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_busy", busy, 0);

      // directed scenarios
      run_cfg(0, 0, 20, 0, 0);
      check("t1_vlmax_8", vlmax, 8);
      run_cfg(3, 5, 7, 0, 0);
      run_cfg(1, 3, 100, 0, 1);
      check("t4_vlmax_32", vlmax, 32);
      run_cfg(0, 0, 0, 0, 0);
      run_cfg(2, 7, 999, 1, 0);
      check("t6_vlmax_1", vlmax, 1);
      run_cfg(4, 0, 5, 0, 0);
      run_cfg(0, 4, 5, 0, 0);
      run_cfg(0, 3, 65535, 0, 0);

      // abort during the second chunk, with a same-cycle handshake offered
      send_cfg(0, 0, 30, 0);
      check("ab_first_valid", chunk_valid, 1);
      check("ab_first_base", chunk_base, 0);
      chunk_ready = 1'b1;
      @(negedge clk);
      check("ab_second_base", chunk_base, 8);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chunk_ready = 1'b0;
      check("ab_valid_dropped", chunk_valid, 0);
      check("ab_idle", busy, 0);
      check("ab_ready_again", cfg_ready, 1);
      check("ab_vlmax_kept", vlmax, 8);
      run_cfg(0, 1, 10, 0, 0);

      // synchronous reset in the middle of issuing
      send_cfg(0, 0, 100, 0);
      check("rs_valid", chunk_valid, 1);
      chunk_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chunk_ready = 1'b0;
      check("rs_chunk_valid", chunk_valid, 0);
      check("rs_vill", vill, 1);
      check("rs_vlmax", vlmax, 0);
      check("rs_base", chunk_base, 0);
      check("rs_cfg_ready", cfg_ready, 1);

      // randomized configs
      for (int i = 0; i < 30; i++) begin
         run_cfg($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 200),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
